// File: rtl/euros_para_centimos.sv
// euros_para_centimos
//   Sequential BCD-to-binary price converter. It takes four BCD digits (EE.CC
//   euros) and returns the price in centimos as a W-bit binary value. One digit
//   is folded in per clock as acc = acc*10 + digit, most significant digit
//   first, under a start/busy/done handshake.
//
// Ports
//   i_clk         clock, all logic on the rising edge
//   i_rst         synchronous active-high reset
//   i_start       conversion request, only sampled while idle
//   i_eur_tens    BCD euros tens digit
//   i_eur_units   BCD euros units digit
//   i_cent_tens   BCD centimos tens digit
//   i_cent_units  BCD centimos units digit
//   o_centimos    binary result, held until the next completed conversion
//   o_busy        conversion in progress
//   o_done        one-cycle pulse when o_centimos/o_ovf/o_err are updated
//   o_ovf         last result did not fit in W bits and was saturated
//   o_err         last request contained a digit greater than 9
//
// state  | meaning
// S_IDLE | waiting for start; invalid requests are answered from here
// S_CONV | folding in one latched digit per cycle, r_idx selects the digit

module euros_para_centimos #(
  parameter int W = 10
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [3:0]   i_eur_tens,
  input  logic [3:0]   i_eur_units,
  input  logic [3:0]   i_cent_tens,
  input  logic [3:0]   i_cent_units,
  output logic [W-1:0] o_centimos,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_ovf,
  output logic         o_err
);

  typedef enum logic {
    S_IDLE,
    S_CONV
  } state_t;

  // Largest representable result, held at accumulator width so the final
  // compare is done before any truncation.
  localparam logic [13:0] MAX_VAL = 14'((1 << W) - 1);

  state_t          r_state;
  logic [13:0]     r_acc;
  logic [1:0]      r_idx;
  logic [3:0][3:0] r_dig;  // index 0 is the most significant digit

  logic [3:0]  w_dig;
  logic [13:0] w_acc_next;
  logic        w_bad;

  assign w_dig = r_dig[r_idx];

  // acc*10 as two shifts and an add; 9999 fits in 14 bits so nothing wraps.
  assign w_acc_next = (r_acc << 3) + (r_acc << 1) + {10'd0, w_dig};

  assign w_bad = (i_eur_tens > 4'd9) || (i_eur_units > 4'd9) ||
                 (i_cent_tens > 4'd9) || (i_cent_units > 4'd9);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_acc      <= '0;
      r_idx      <= '0;
      r_dig      <= '0;
      o_centimos <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_ovf      <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            r_dig[0] <= i_eur_tens;
            r_dig[1] <= i_eur_units;
            r_dig[2] <= i_cent_tens;
            r_dig[3] <= i_cent_units;
            if (w_bad) begin
              o_centimos <= '0;
              o_err      <= 1'b1;
              o_ovf      <= 1'b0;
              o_done     <= 1'b1;
            end else begin
              r_acc   <= '0;
              r_idx   <= '0;
              o_busy  <= 1'b1;
              r_state <= S_CONV;
            end
          end
        end

        S_CONV: begin
          o_done <= 1'b0;
          r_acc  <= w_acc_next;
          r_idx  <= r_idx + 2'd1;
          if (r_idx == 2'd3) begin
            if (w_acc_next > MAX_VAL) begin
              o_centimos <= '1;
              o_ovf      <= 1'b1;
            end else begin
              o_centimos <= w_acc_next[W-1:0];
              o_ovf      <= 1'b0;
            end
            o_err   <= 1'b0;
            o_done  <= 1'b1;
            o_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
          o_busy  <= 1'b0;
          o_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_euros_para_centimos.sv
module tb_euros_para_centimos;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] d_et = '0, d_eu = '0, d_ct = '0, d_cu = '0;

  logic [9:0] cent10;
  logic       busy10, done10, ovf10, err10;
  logic [7:0] cent8;
  logic       busy8, done8, ovf8, err8;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  euros_para_centimos #(.W(10)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .i_eur_tens(d_et), .i_eur_units(d_eu), .i_cent_tens(d_ct), .i_cent_units(d_cu),
    .o_centimos(cent10), .o_busy(busy10), .o_done(done10), .o_ovf(ovf10), .o_err(err10)
  );

  euros_para_centimos #(.W(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .i_eur_tens(d_et), .i_eur_units(d_eu), .i_cent_tens(d_ct), .i_cent_units(d_cu),
    .o_centimos(cent8), .o_busy(busy8), .o_done(done8), .o_ovf(ovf8), .o_err(err8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present digits with start for one edge; returns 1 ns after that edge.
  task automatic do_start(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input logic [3:0] d);
    d_et = a; d_eu = b; d_ct = c; d_cu = d;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Full valid conversion on the W=10 instance with exact cycle checks.
  task automatic run_conv(input string tag,
                          input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input logic [3:0] d,
                          input int exp_cent, input logic exp_ovf);
    do_start(a, b, c, d);
    for (int i = 0; i < 4; i++) begin
      chk({tag, " busy"}, 32'(busy10), 32'd1);
      chk({tag, " no early done"}, 32'(done10), 32'd0);
      step();
    end
    chk({tag, " done"}, 32'(done10), 32'd1);
    chk({tag, " busy low at done"}, 32'(busy10), 32'd0);
    chk({tag, " centimos"}, 32'(cent10), 32'(exp_cent));
    chk({tag, " ovf"}, 32'(ovf10), 32'(exp_ovf));
    chk({tag, " err"}, 32'(err10), 32'd0);
  endtask

  initial begin
    int dcount;

    // Reset
    step();
    step();
    rst = 1'b0;
    chk("rst centimos", 32'(cent10), 32'd0);
    chk("rst busy", 32'(busy10), 32'd0);
    chk("rst done", 32'(done10), 32'd0);
    chk("rst ovf", 32'(ovf10), 32'd0);
    chk("rst err", 32'(err10), 32'd0);
    chk("rst centimos w8", 32'(cent8), 32'd0);
    step();

    // 02.50 and the W=10 saturation boundary, back to back
    run_conv("02.50", 4'd0, 4'd2, 4'd5, 4'd0, 250, 1'b0);
    run_conv("10.23", 4'd1, 4'd0, 4'd2, 4'd3, 1023, 1'b0);
    run_conv("10.24", 4'd1, 4'd0, 4'd2, 4'd4, 1023, 1'b1);
    run_conv("99.99", 4'd9, 4'd9, 4'd9, 4'd9, 1023, 1'b1);
    run_conv("00.00", 4'd0, 4'd0, 4'd0, 4'd0, 0, 1'b0);
    step();
    chk("done one cycle", 32'(done10), 32'd0);

    // Invalid digit
    do_start(4'd0, 4'd0, 4'd0, 4'hA);
    chk("bad done", 32'(done10), 32'd1);
    chk("bad err", 32'(err10), 32'd1);
    chk("bad centimos", 32'(cent10), 32'd0);
    chk("bad ovf", 32'(ovf10), 32'd0);
    chk("bad busy", 32'(busy10), 32'd0);
    step();
    chk("bad done drops", 32'(done10), 32'd0);
    chk("bad busy stays low", 32'(busy10), 32'd0);
    run_conv("01.00", 4'd0, 4'd1, 4'd0, 4'd0, 100, 1'b0);
    step();

    // Start during busy is ignored and digits change after the start edge
    do_start(4'd0, 4'd5, 4'd0, 4'd0);
    chk("05.00 busy0", 32'(busy10), 32'd1);
    step();
    d_et = 4'd9; d_eu = 4'd9; d_ct = 4'd9; d_cu = 4'd9;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("05.00 busy2", 32'(busy10), 32'd1);
    chk("05.00 no early done", 32'(done10), 32'd0);
    step();
    step();
    chk("05.00 done", 32'(done10), 32'd1);
    chk("05.00 centimos", 32'(cent10), 32'd500);
    chk("05.00 ovf", 32'(ovf10), 32'd0);
    // Start in the done cycle; run_conv also proves no second done follows.
    run_conv("00.07", 4'd0, 4'd0, 4'd0, 4'd7, 7, 1'b0);
    step();

    // Reset in the second busy cycle aborts
    do_start(4'd0, 4'd7, 4'd7, 4'd7);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort centimos", 32'(cent10), 32'd0);
    chk("abort busy", 32'(busy10), 32'd0);
    chk("abort done", 32'(done10), 32'd0);
    chk("abort ovf", 32'(ovf10), 32'd0);
    chk("abort err", 32'(err10), 32'd0);
    dcount = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done10 === 1'b1) dcount++;
    end
    chk("abort no done", 32'(dcount), 32'd0);
    chk("abort centimos held", 32'(cent10), 32'd0);
    run_conv("01.23", 4'd0, 4'd1, 4'd2, 4'd3, 123, 1'b0);
    step();

    // W=8 boundary, checked on the second instance alongside W=10
    run_conv("02.55", 4'd0, 4'd2, 4'd5, 4'd5, 255, 1'b0);
    chk("w8 02.55 done", 32'(done8), 32'd1);
    chk("w8 02.55 centimos", 32'(cent8), 32'd255);
    chk("w8 02.55 ovf", 32'(ovf8), 32'd0);
    run_conv("02.56", 4'd0, 4'd2, 4'd5, 4'd6, 256, 1'b0);
    chk("w8 02.56 done", 32'(done8), 32'd1);
    chk("w8 02.56 centimos", 32'(cent8), 32'd255);
    chk("w8 02.56 ovf", 32'(ovf8), 32'd1);
    chk("w8 02.56 err", 32'(err8), 32'd0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/euros_para_centimos.md
# euros_para_centimos

Sequential BCD-to-binary price converter for the Balanca datapath, the inverse of the existing centimos-to-euros conversion. It accepts a price entered as four BCD digits (EE.CC euros) and produces the binary price in centimos on the same 10-bit price bus the rest of the scale logic uses. Conversion is iterative, one digit per clock (acc = acc*10 + digit), under a start/busy/done handshake. Invalid-digit and overflow conditions are flagged.

## Interface
- W, 10: width of the binary centimos result. Internal accumulator is fixed at 14 bits, which covers 9999.
- clk  in  1: single clock; all logic on rising edge.
- rst  in  1: synchronous, active-high reset.
- start  in  1: request conversion; sampled only when busy=0.
- eur_tens  in  4: BCD euros tens digit.
- eur_units  in  4: BCD euros units digit.
- cent_tens  in  4: BCD centimos tens digit.
- cent_units  in  4: BCD centimos units digit.
- centimos  out  W: binary price result; held until the next completed conversion.
- busy  out  1: conversion in progress.
- done  out  1: one-cycle pulse when centimos, ovf and err are updated.
- ovf  out  1: last result exceeded 2^W-1 and was saturated.
- err  out  1: last request contained a digit >9.

## Operation
- States: IDLE, CONV.
- IDLE, start=1:
  - Latch all four digits.
  - If any latched digit >9: stay IDLE, centimos<=0, err<=1, ovf<=0, done<=1.
  - Otherwise: acc<=0, idx<=0, busy<=1, go to CONV.
- IDLE, start=0: hold all outputs. done<=0.
- CONV, each cycle: acc <= acc*10 + digit[idx], with digits MSD first (eur_tens, eur_units, cent_tens, cent_units). idx increments.
  - acc*10 is computed as (acc<<3)+(acc<<1) at 14-bit width. No multiplier is used.
- CONV, idx==3 (last digit): compute v = acc*10 + cent_units.
  - If v > 2^W-1: centimos <= all-ones, ovf<=1.
  - Else: centimos <= v[W-1:0], ovf<=0.
  - err<=0, done<=1, busy<=0, go to IDLE.
- start while busy=1 is ignored. It is not queued.
- Digit inputs may change freely after the start cycle; only latched copies are used.
- done is never high for two consecutive cycles from a single request.
- A new start in the cycle where done=1 is accepted (state is already IDLE).
- Reset value of every output:
  - centimos=0, busy=0, done=0, ovf=0, err=0.
  - State IDLE; acc and idx cleared.
- rst during CONV aborts the conversion. No done pulse follows, and the previous result is lost (centimos=0).

## Timing
- Let the start cycle be the clock edge at which start=1 is sampled in IDLE.
- Valid request:
  - busy is high from the cycle after that edge through 4 cycles.
  - done is high for exactly the 4th cycle after that edge, with centimos, ovf and err valid in that same cycle.
  - busy is low when done is high.
- Invalid request: done and err are high in the 1st cycle after that edge; busy never rises.
- Throughput: one conversion per 5 cycles with back-to-back starts (start re-asserted in the done cycle).
- Width rule: the accumulator never wraps (max 9999 < 2^14). Saturation is applied only at the final compare.

## Test plan
- Digits 0,2,5,0 (02.50 euros), start 1 cycle → busy high for 4 cycles; done on cycle 4 with centimos=250, ovf=0, err=0.
- 10.23 → centimos=1023, ovf=0. Then 10.24 → centimos=1023, ovf=1. Then 99.99 → centimos=1023, ovf=1. Then 00.00 → centimos=0, ovf=0.
- cent_units=4'hA with start → done and err high 1 cycle later, centimos=0, busy stays 0. Next valid 01.00 → centimos=100, err=0.
- Start 05.00. Change the digits and pulse start again during busy → single done with centimos=500, and no second done. Then start in the done cycle with 00.07 → second result 7 exactly 4 cycles later.
- Start 07.77 and assert rst for 1 cycle at the 2nd busy cycle → all outputs 0, no done pulse within 10 cycles. A subsequent 01.23 converts to 123.
- Parameter W=8 build: 02.55 → 255, ovf=0; 02.56 → 255, ovf=1.
